// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: synchronised inputs, atomic set/clear/toggle outputs, polarity select.
// Define GPIO_IRQ_EN to build the edge-detect interrupt (RISE_EN, FALL_EN, IRQ_STAT, irq).
module gpio_ctrl #(
   parameter int WIDTH_OUT      = 8,
   parameter int WIDTH_IN       = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int OUT_ACTIVE_LOW = 1,
   parameter logic [WIDTH_OUT-1:0] OUT_RESET = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 wre,
   input  logic [2:0]           addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   input  logic [WIDTH_IN-1:0]  gpio_in,
   output logic [WIDTH_OUT-1:0] gpio_out,
   output logic                 irq
);

   localparam logic POL = (OUT_ACTIVE_LOW != 0);

   logic                 wr_s;
   logic                 rd_s;
   logic [WIDTH_OUT-1:0] wd_out_s;
   logic [WIDTH_IN-1:0]  wd_in_s;
   logic [WIDTH_OUT-1:0] out_r;
   logic [WIDTH_OUT-1:0] out_n;
   logic [WIDTH_IN-1:0]  sync_r [SYNC_STAGES];
   logic [WIDTH_IN-1:0]  s_s;
   logic [31:0]          rdata_r;
   logic [31:0]          rdata_n;
   logic                 unused_wdata;

   assign wr_s         = en & wre;
   assign rd_s         = en & ~wre;
   assign wd_out_s     = wdata[WIDTH_OUT-1:0];
   assign wd_in_s      = wdata[WIDTH_IN-1:0];
   assign unused_wdata = ^wdata;
   assign s_s          = sync_r[SYNC_STAGES-1];
   assign gpio_out     = out_r ^ {WIDTH_OUT{POL}};
   assign rdata        = rdata_r;

   always_comb begin
      out_n = out_r;
      if (wr_s) begin
         case (addr)
            3'd0:    out_n = wd_out_s;
            3'd1:    out_n = out_r | wd_out_s;
            3'd2:    out_n = out_r & ~wd_out_s;
            3'd3:    out_n = out_r ^ wd_out_s;
            default: out_n = out_r;
         endcase
      end else begin
         out_n = out_r;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_r <= OUT_RESET;
         for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
      end else begin
         out_r     <= out_n;
         sync_r[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      end
   end

`ifdef GPIO_IRQ_EN
   // Edge events are masked until the synchroniser and prev flops hold real pin data.
   localparam logic [2:0] SETTLE_N = 3'(SYNC_STAGES + 1);

   logic [WIDTH_IN-1:0] prev_r;
   logic [WIDTH_IN-1:0] rise_en_r;
   logic [WIDTH_IN-1:0] fall_en_r;
   logic [WIDTH_IN-1:0] irq_stat_r;
   logic [WIDTH_IN-1:0] irq_stat_n;
   logic [WIDTH_IN-1:0] event_s;
   logic [WIDTH_IN-1:0] clr_s;
   logic [2:0]          settle_r;
   logic                settled_s;

   assign settled_s = (settle_r == SETTLE_N);
   assign event_s   = settled_s ? ((s_s & ~prev_r & rise_en_r) | (~s_s & prev_r & fall_en_r))
                                : {WIDTH_IN{1'b0}};
   assign irq       = |irq_stat_r;

   always_comb begin
      clr_s      = {WIDTH_IN{1'b0}};
      irq_stat_n = irq_stat_r;
      if (wr_s && (addr == 3'd7)) begin
         clr_s = wd_in_s;
      end else begin
         clr_s = {WIDTH_IN{1'b0}};
      end
      irq_stat_n = (irq_stat_r & ~clr_s) | event_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_r     <= '0;
         rise_en_r  <= '0;
         fall_en_r  <= '0;
         irq_stat_r <= '0;
         settle_r   <= 3'd0;
      end else begin
         prev_r     <= s_s;
         irq_stat_r <= irq_stat_n;
         if (!settled_s) settle_r <= settle_r + 3'd1;
         if (wr_s && (addr == 3'd5)) rise_en_r <= wd_in_s;
         if (wr_s && (addr == 3'd6)) fall_en_r <= wd_in_s;
      end
   end
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rdata_n = 32'd0;
      case (addr)
         3'd0, 3'd1, 3'd2, 3'd3: rdata_n[WIDTH_OUT-1:0] = out_r;
         3'd4:                   rdata_n[WIDTH_IN-1:0]  = s_s;
`ifdef GPIO_IRQ_EN
         3'd5:                   rdata_n[WIDTH_IN-1:0]  = rise_en_r;
         3'd6:                   rdata_n[WIDTH_IN-1:0]  = fall_en_r;
         3'd7:                   rdata_n[WIDTH_IN-1:0]  = irq_stat_r;
`endif
         default:                rdata_n = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r <= 32'd0;
      end else if (rd_s) begin
         rdata_r <= rdata_n;
      end else begin
         rdata_r <= rdata_r;
      end
   end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl (8 in / 8 out, 2 sync stages, active-low, reset A5).
module tb_gpio_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        wre;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic        irq;
   logic [31:0] rd;
   int          checks = 0;
   int          errors = 0;

   gpio_ctrl #(
      .WIDTH_OUT(8), .WIDTH_IN(8), .SYNC_STAGES(2),
      .OUT_ACTIVE_LOW(1), .OUT_RESET(8'hA5)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .wre(wre), .addr(addr), .wdata(wdata),
      .rdata(rdata), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      en = 1'b1; wre = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      en = 1'b0; wre = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      en = 1'b1; wre = 1'b0; addr = a;
      @(negedge clk);
      en = 1'b0;
      d = rdata;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; wre = 1'b0; addr = 3'd0; wdata = 32'd0; gpio_in = 8'h00;
      tick(3);
      check_val("rst_gpio_out", {24'd0, gpio_out}, 32'h0000005A);
      check_val("rst_rdata", rdata, 32'h00000000);
      check_val("rst_irq", {31'd0, irq}, 32'd0);
      rst = 1'b0;

      bus_read(3'd0, rd);  check_val("rd_out_reset", rd, 32'h000000A5);

      bus_write(3'd0, 32'h0000000F);
      check_val("out_wr_pin", {24'd0, gpio_out}, 32'h000000F0);
      check_val("rdata_hold_wr", rdata, 32'h000000A5);
      bus_read(3'd0, rd);  check_val("rd_out_0f", rd, 32'h0000000F);
      bus_write(3'd1, 32'h000000F0);
      check_val("set_pin", {24'd0, gpio_out}, 32'h00000000);
      bus_read(3'd0, rd);  check_val("rd_set", rd, 32'h000000FF);
      bus_write(3'd2, 32'h00000003);
      check_val("clr_pin", {24'd0, gpio_out}, 32'h00000003);
      bus_read(3'd0, rd);  check_val("rd_clr", rd, 32'h000000FC);
      bus_write(3'd3, 32'h00000081);
      check_val("tgl_pin", {24'd0, gpio_out}, 32'h00000082);
      bus_read(3'd0, rd);  check_val("rd_tgl", rd, 32'h0000007D);
      tick(2);
      check_val("rdata_hold_idle", rdata, 32'h0000007D);
      bus_read(3'd1, rd);  check_val("rd_set_addr", rd, 32'h0000007D);
      bus_read(3'd2, rd);  check_val("rd_clr_addr", rd, 32'h0000007D);
      bus_read(3'd3, rd);  check_val("rd_tgl_addr", rd, 32'h0000007D);
      bus_write(3'd4, 32'hFFFFFFFF);
      bus_read(3'd0, rd);  check_val("in_wr_ignored", rd, 32'h0000007D);
      bus_write(3'd0, 32'hFFFFFF00);
      bus_read(3'd0, rd);  check_val("upper_bits_ignored", rd, 32'h00000000);
      check_val("upper_pin", {24'd0, gpio_out}, 32'h000000FF);

      // Pin change and read on the same edge: synchroniser still holds the old value.
      gpio_in = 8'h3C;
      bus_read(3'd4, rd);  check_val("in_not_yet", rd, 32'h00000000);
      tick(3);
      bus_read(3'd4, rd);  check_val("in_sync", rd, 32'h0000003C);

`ifdef GPIO_IRQ_EN
      gpio_in = 8'h00;
      tick(4);
      bus_write(3'd5, 32'h00000001);
      bus_read(3'd5, rd);  check_val("rise_en_rd", rd, 32'h00000001);
      gpio_in = 8'h01;
      tick(1); check_val("irq_lat_k", {31'd0, irq}, 32'd0);
      tick(1); check_val("irq_lat_k1", {31'd0, irq}, 32'd0);
      tick(1); check_val("irq_lat_k2", {31'd0, irq}, 32'd1);
      bus_read(3'd7, rd);  check_val("stat_rise", rd, 32'h00000001);
      bus_write(3'd7, 32'h00000001);
      check_val("irq_cleared", {31'd0, irq}, 32'd0);
      bus_read(3'd7, rd);  check_val("stat_cleared", rd, 32'h00000000);

      // Re-arm bit 0, then clear it on the very edge a new rise sets it.
      gpio_in = 8'h00; tick(4);
      gpio_in = 8'h01; tick(4);
      gpio_in = 8'h00; tick(4);
      check_val("stat_rearmed", {31'd0, irq}, 32'd1);
      gpio_in = 8'h01;
      tick(2);
      bus_write(3'd7, 32'h00000001);
      check_val("set_wins_irq", {31'd0, irq}, 32'd1);
      bus_read(3'd7, rd);  check_val("set_wins_stat", rd, 32'h00000001);
      bus_write(3'd7, 32'h000000FF);
      check_val("irq_cleared2", {31'd0, irq}, 32'd0);
`else
      bus_write(3'd5, 32'h000000FF);
      bus_write(3'd6, 32'h000000FF);
      bus_write(3'd7, 32'h000000FF);
      gpio_in = 8'hC3; tick(3);
      gpio_in = 8'h00; tick(3);
      bus_read(3'd5, rd);  check_val("noirq_rd5", rd, 32'h00000000);
      bus_read(3'd6, rd);  check_val("noirq_rd6", rd, 32'h00000000);
      bus_read(3'd7, rd);  check_val("noirq_rd7", rd, 32'h00000000);
      check_val("noirq_irq", {31'd0, irq}, 32'd0);
      bus_read(3'd4, rd);  check_val("noirq_in", rd, 32'h00000000);
      bus_read(3'd0, rd);  check_val("noirq_out_kept", rd, 32'h00000000);
`endif

      // Mid-operation reset with all pins already high.
      gpio_in = 8'hFF;
      rst = 1'b1;
      tick(3);
      check_val("rst2_gpio_out", {24'd0, gpio_out}, 32'h0000005A);
      check_val("rst2_rdata", rdata, 32'h00000000);
      check_val("rst2_irq", {31'd0, irq}, 32'd0);
      rst = 1'b0;
`ifdef GPIO_IRQ_EN
      bus_write(3'd5, 32'h000000FF);
      tick(6);
      check_val("settle_irq", {31'd0, irq}, 32'd0);
      bus_read(3'd7, rd);  check_val("settle_stat", rd, 32'h00000000);
      bus_write(3'd6, 32'h00000004);
      gpio_in = 8'hFB;
      tick(4);
      bus_read(3'd7, rd);  check_val("fall_stat", rd, 32'h00000004);
      check_val("fall_irq", {31'd0, irq}, 32'd1);
`else
      tick(4);
      bus_read(3'd4, rd);  check_val("rst2_in", rd, 32'h000000FF);
      check_val("rst2_irq_late", {31'd0, irq}, 32'd0);
`endif
      bus_read(3'd0, rd);  check_val("rst2_out", rd, 32'h000000A5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
